// File: rtl/cop0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause bit positions.
// Latency: n/a (constants and one pure helper function).
// Backpressure: n/a.
package cop0_pkg;

  // CP0 register numbers (rd field of MFC0/MTC0)
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

  // Cause bit positions
  localparam int CA_EXC_LO   = 2;
  localparam int CA_EXC_HI   = 6;
  localparam int CA_IP_LO    = 8;
  localparam int CA_IP_HI    = 15;
  localparam int CA_IP_SW_LO = 8;
  localparam int CA_IP_SW_HI = 9;

  // Priority encode of the exception cause: interrupt beats reserved
  // instruction, which beats overflow.
  function automatic logic [4:0] exc_code(input logic intr, input logic ri);
    if (intr)    return EXC_INT;
    else if (ri) return EXC_RI;
    else         return EXC_OV;
  endfunction

endpackage

// File: rtl/cop0_irq_sync.sv
// Multi-flop synchronizer for the asynchronous hardware interrupt lines.
// Latency: STAGES clocks from i_async to o_sync.
// Backpressure: none; free-running every clock.
//
// Ports: i_clk, i_rst_n (async, active-low), i_async[WIDTH] raw lines,
//        o_sync[WIDTH] synchronized lines.
module cop0_irq_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) chain[s] <= '0;
    end else begin
      chain[0] <= i_async;
      for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
    end
  end

  assign o_sync = chain[STAGES-1];

endmodule

// File: rtl/cop0_exc_unit.sv
// CP0 register file (Status/Cause/EPC/Count/Compare) and exception/interrupt sequencer.
// Latency: kill/redirect/rdata combinational in the instruction's cycle; state updates at the edge.
// Backpressure: none; one instruction per i_instr_valid, timer and Count run every clock.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_instr_valid, i_pc and the
//        decoder strobes (i_mfc0, i_mtc0, i_eret, i_unknown_func) plus i_overflow describe
//        the completing instruction; i_cp0_addr/i_wdata address and data for MFC0/MTC0;
//        i_irq raw interrupt lines (IP2..IP6). o_rdata MFC0 data, o_kill suppresses the
//        instruction's writes, o_redirect/o_redirect_pc override the next PC, o_exl = Status.EXL.
module cop0_exc_unit
  import cop0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0180,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_instr_valid,
  input  logic [31:0] i_pc,
  input  logic        i_mfc0,
  input  logic        i_mtc0,
  input  logic        i_eret,
  input  logic        i_unknown_func,
  input  logic        i_overflow,
  input  logic [4:0]  i_cp0_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_irq,
  output logic [31:0] o_rdata,
  output logic        o_kill,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_exl
);

  // Architectural state
  logic [7:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic [1:0]  sw_ip_q;
  logic        timer_ip_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;

  logic [4:0]  irq_sync;

  cop0_irq_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (5)
  ) u_irq_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_irq),
    .o_sync  (irq_sync)
  );

  // Cause.IP: timer sticky flag, live hardware lines, software bits
  logic [7:0] ip;
  assign ip = {timer_ip_q, irq_sync, sw_ip_q};

  // Exception decode. Gating with i_rst_n keeps kill/redirect low while
  // reset is held even if the decoder strobes are active.
  logic        live;
  logic        exc_int;
  logic        exc_ri;
  logic        exc_ov;
  logic        take_exc;
  logic        eret_ok;
  logic        mtc0_we;
  logic [4:0]  exc_code_nxt;

  always_comb begin
    live         = i_instr_valid & i_rst_n;
    exc_int      = live & ie_q & ~exl_q & (|(ip & im_q));
    // ERET outside exception level is treated as a reserved instruction
    exc_ri       = live & (i_unknown_func | (i_eret & ~exl_q));
    exc_ov       = live & i_overflow;
    take_exc     = exc_int | exc_ri | exc_ov;
    eret_ok      = live & i_eret & exl_q & ~take_exc;
    // A faulting MTC0 must not modify any register
    mtc0_we      = live & i_mtc0 & ~take_exc;
    exc_code_nxt = exc_code(exc_int, exc_ri);
  end

  assign o_kill        = take_exc;
  assign o_redirect    = take_exc | eret_ok;
  assign o_redirect_pc = eret_ok ? epc_q : EXC_VECTOR;
  assign o_exl         = exl_q;

  // Count: MTC0 load replaces the increment for that cycle
  logic [31:0] count_nxt;
  logic        timer_hit;
  logic        compare_we;

  always_comb begin
    if (mtc0_we && i_cp0_addr == CP0_COUNT) count_nxt = i_wdata;
    else                                    count_nxt = count_q + 32'd1;
    timer_hit  = (count_nxt == compare_q);
    compare_we = mtc0_we && (i_cp0_addr == CP0_COMPARE);
  end

  // MFC0 read mux: pre-edge register images
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  always_comb begin
    status_rd                     = '0;
    status_rd[ST_IM_HI:ST_IM_LO]  = im_q;
    status_rd[ST_EXL]             = exl_q;
    status_rd[ST_IE]              = ie_q;
    cause_rd                      = '0;
    cause_rd[CA_IP_HI:CA_IP_LO]   = ip;
    cause_rd[CA_EXC_HI:CA_EXC_LO] = exc_code_q;
    o_rdata                       = '0;
    if (i_mfc0) begin
      case (i_cp0_addr)
        CP0_COUNT:   o_rdata = count_q;
        CP0_COMPARE: o_rdata = compare_q;
        CP0_STATUS:  o_rdata = status_rd;
        CP0_CAUSE:   o_rdata = cause_rd;
        CP0_EPC:     o_rdata = epc_q;
        default:     o_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      sw_ip_q    <= '0;
      timer_ip_q <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
      count_q    <= '0;
      compare_q  <= '0;
    end else begin
      count_q <= count_nxt;

      // Writing Compare acknowledges the timer; it wins over a same-edge match
      if (compare_we) begin
        compare_q  <= i_wdata;
        timer_ip_q <= 1'b0;
      end else if (timer_hit) begin
        timer_ip_q <= 1'b1;
      end

      if (mtc0_we) begin
        case (i_cp0_addr)
          CP0_STATUS: begin
            im_q  <= i_wdata[ST_IM_HI:ST_IM_LO];
            exl_q <= i_wdata[ST_EXL];
            ie_q  <= i_wdata[ST_IE];
          end
          CP0_CAUSE: sw_ip_q <= i_wdata[CA_IP_SW_HI:CA_IP_SW_LO];
          CP0_EPC:   epc_q   <= i_wdata;
          default: ;
        endcase
      end

      // A nested exception (EXL already set) keeps the original return
      // address but still records the newest cause.
      if (take_exc) begin
        exc_code_q <= exc_code_nxt;
        if (!exl_q) begin
          epc_q <= i_pc;
          exl_q <= 1'b1;
        end
      end else if (eret_ok) begin
        exl_q <= 1'b0;
      end
    end
  end

endmodule
